// File: rtl/adc_conv_ctrl.sv
// adc_conv_ctrl: periodic SAR ADC start/capture, 2**AVG_LOG2 averaging and output FIFO
module adc_conv_ctrl #(
   parameter int DATA_W     = 8,
   parameter int AVG_LOG2   = 2,
   parameter int PERIOD_W   = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15,
   parameter int MIN_PERIOD = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic                err_clr,
   output logic                adc_start,
   input  logic                adc_eoc,
   input  logic [DATA_W-1:0]   adc_dig_val,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                overflow,
   output logic                timeout_err
);
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_CONV  = 3'd2;
   localparam logic [2:0] S_PUSH  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [PERIOD_W-1:0] timer_q, timer_d, eff_q, eff_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [AW:0]         count_q;
   logic                ovf_q, tmo_q;
   logic                eoc_hit, tmo_hit, last, clr_acc, push, pop, full, wr_en;

   // timer_q counts cycles since the last start, so it doubles as the eoc timeout
   assign eoc_hit = state_q == S_CONV && adc_eoc;
   assign tmo_hit = state_q == S_CONV && !adc_eoc && timer_q >= PERIOD_W'(TIMEOUT - 1);
   assign last    = cnt_q == CNT_W'((1 << AVG_LOG2) - 1);
   assign clr_acc = tmo_hit || state_q == S_PUSH || (state_q == S_WAIT && !enable);
   assign push    = state_q == S_PUSH;
   assign full    = count_q == (AW + 1)'(FIFO_DEPTH);
   assign pop     = out_valid && out_ready;
   assign wr_en   = push && (!full || pop);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = enable ? S_START : S_IDLE;
         S_START: state_d = S_CONV;
         S_CONV:  state_d = eoc_hit ? (last ? S_PUSH : S_WAIT) : (tmo_hit ? S_WAIT : S_CONV);
         S_PUSH:  state_d = S_WAIT;
         S_WAIT:  state_d = !enable ? S_IDLE : (timer_q >= eff_q - PERIOD_W'(1)) ? S_START : S_WAIT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      timer_d = state_q == S_START ? PERIOD_W'(1) : (&timer_q ? timer_q : timer_q + PERIOD_W'(1));
      eff_d   = state_q == S_START ? (period < PERIOD_W'(MIN_PERIOD) ? PERIOD_W'(MIN_PERIOD) : period) : eff_q;
      acc_d   = clr_acc ? '0 : eoc_hit ? acc_q + ACC_W'(adc_dig_val) : acc_q;
      cnt_d   = clr_acc ? '0 : eoc_hit ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         eff_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         eff_q   <= eff_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_q + AW'(wr_en);
         rd_q    <= rd_q + AW'(pop);
         count_q <= count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
         ovf_q   <= (push && full && !pop) || (ovf_q && !err_clr);
         tmo_q   <= tmo_hit || (tmo_q && !err_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= DATA_W'(acc_q >> AVG_LOG2);
   end

   assign out_valid   = count_q != '0;
   assign out_data    = out_valid ? mem_q[rd_q] : '0;
   assign adc_start   = state_q == S_START;
   assign busy        = state_q != S_IDLE;
   assign overflow    = ovf_q;
   assign timeout_err = tmo_q;
endmodule
